// File: rtl/vm_proj_readout.sv
`default_nettype none
// ============================================================================
// vm_proj_readout : counts VM projection writes per event, streams them out
// Optional paging: VM_PROJ_READOUT_PAGE_EN          Revision: 1.0
// ============================================================================
module vm_proj_readout #(
    parameter int ADDR_W      = 9,
    parameter int RD_LAT      = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int MAX_ENTRIES = 511
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              wr_en_phi1z1,
    input  logic              wr_en_phi1z2,
    input  logic              wr_en_phi2z1,
    input  logic              wr_en_phi2z2,
    input  logic              wr_en_phi3z1,
    input  logic              wr_en_phi3z2,
`ifdef VM_PROJ_READOUT_PAGE_EN
    output logic [ADDR_W:0]   rd_add,
`else
    output logic [ADDR_W-1:0] rd_add,
`endif
    output logic              rd_en,
    input  logic [12:0]       mem_phi1z1,
    input  logic [12:0]       mem_phi1z2,
    input  logic [12:0]       mem_phi2z1,
    input  logic [12:0]       mem_phi2z2,
    input  logic [12:0]       mem_phi3z1,
    input  logic [12:0]       mem_phi3z2,
    output logic [15:0]       vmp_data,
    output logic              vmp_valid,
    input  logic              vmp_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LAT + 1);
    localparam logic [ADDR_W-1:0] C_MAX = ADDR_W'(MAX_ENTRIES);
    localparam logic [ADDR_W-1:0] C_ONE = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt [6];
    logic [ADDR_W-1:0] r_snap [6];
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_vm_sel;
    logic [5:0]        w_wr, w_cnt_nz, w_snap_nz, w_sat_hit, w_above;
    logic [3:0]        w_first, w_next;
    logic              w_take, w_dup_start, w_last_of_vm, w_credit, r_overflow;
    logic [RD_LAT-1:0] r_pipe_vld;
    logic [2:0]        r_pipe_vm [RD_LAT];
    logic [15:0]       r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic [SUM_W-1:0]  w_inflight;
    logic [12:0]       w_mem_sel;
    logic              w_push, w_pop, w_drained;

    // {found, index} of the lowest set bit
    function automatic logic [3:0] pick_lowest(input logic [5:0] mask);
        logic [3:0] r;
        r = 4'd0;
        for (int i = 5; i >= 0; i--) begin
            if (mask[i]) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_wr = {wr_en_phi3z2, wr_en_phi3z1, wr_en_phi2z2,
                   wr_en_phi2z1, wr_en_phi1z2, wr_en_phi1z1};

`ifdef VM_PROJ_READOUT_PAGE_EN
    logic r_pending, r_page, r_rd_page;
    assign w_take      = (r_state == S_IDLE) && (start || r_pending);
    assign w_dup_start = start && r_pending && (r_state != S_IDLE);
    assign rd_add      = {r_rd_page, r_addr};

    // Router writes r_page; the readout walks the page closed by the last start
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_page    <= 1'b0;
            r_rd_page <= 1'b0;
        end else if (w_take) begin
            r_pending <= start && r_pending;
            r_page    <= ~r_page;
            r_rd_page <= r_page;
        end else if (start) begin
            r_pending <= 1'b1;
        end
    end
`else
    assign w_take      = (r_state == S_IDLE) && start;
    assign w_dup_start = 1'b0;
    assign rd_add      = r_addr;
`endif

    always_comb begin
        w_cnt_nz  = '0;
        w_snap_nz = '0;
        w_sat_hit = '0;
        for (int i = 0; i < 6; i++) begin
            w_cnt_nz[i]  = (r_cnt[i] != '0);
            w_snap_nz[i] = (r_snap[i] != '0);
            w_sat_hit[i] = w_wr[i] && !w_take && (r_cnt[i] == C_MAX - C_ONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 6; i++) begin
                r_cnt[i]  <= '0;
                r_snap[i] <= '0;
            end
            r_overflow <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (w_take) begin
                    r_snap[i] <= r_cnt[i];
                    r_cnt[i]  <= w_wr[i] ? C_ONE : '0;
                end else if (w_wr[i] && (r_cnt[i] != C_MAX)) begin
                    r_cnt[i] <= r_cnt[i] + C_ONE;
                end
            end
            if ((|w_sat_hit) || w_dup_start) r_overflow <= 1'b1;
        end
    end
    assign overflow = r_overflow;

    assign w_first      = pick_lowest(w_cnt_nz);
    assign w_above      = 6'h3f << (r_vm_sel + 3'd1);
    assign w_next       = pick_lowest(w_snap_nz & w_above);
    assign w_last_of_vm = (r_addr == r_snap[r_vm_sel] - C_ONE);

    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < RD_LAT; i++) w_inflight = w_inflight + SUM_W'(r_pipe_vld[i]);
    end
    assign w_credit  = (SUM_W'(r_occ) + w_inflight) < SUM_W'(FIFO_DEPTH);
    assign w_drained = (w_inflight == '0) &&
                       ((r_occ == '0) || ((r_occ == OCC_W'(1)) && w_pop));

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        rd_en       = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (w_take) w_state_nxt = w_first[3] ? S_READ : S_DONE;
            S_READ: begin
                busy = 1'b1;
                if (w_credit) begin
                    rd_en = 1'b1;
                    if (w_last_of_vm && !w_next[3]) w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (w_drained) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Moving to the next VM restarts at address 0 in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr   <= '0;
            r_vm_sel <= 3'd0;
        end else if (w_take) begin
            r_addr   <= '0;
            r_vm_sel <= w_first[2:0];
        end else if (rd_en) begin
            if (w_last_of_vm) begin
                r_addr <= '0;
                if (w_next[3]) r_vm_sel <= w_next[2:0];
            end else begin
                r_addr <= r_addr + C_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_pipe_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_vm[i] <= 3'd0;
        end else begin
            r_pipe_vld[0] <= rd_en;
            r_pipe_vm[0]  <= r_vm_sel;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_vm[i]  <= r_pipe_vm[i-1];
            end
        end
    end

    always_comb begin
        w_mem_sel = 13'd0;
        case (r_pipe_vm[RD_LAT-1])
            3'd0:    w_mem_sel = mem_phi1z1;
            3'd1:    w_mem_sel = mem_phi1z2;
            3'd2:    w_mem_sel = mem_phi2z1;
            3'd3:    w_mem_sel = mem_phi2z2;
            3'd4:    w_mem_sel = mem_phi3z1;
            3'd5:    w_mem_sel = mem_phi3z2;
            default: w_mem_sel = 13'd0;
        endcase
    end

    assign w_push    = r_pipe_vld[RD_LAT-1];
    assign vmp_valid = (r_occ != '0);
    assign w_pop     = vmp_valid && vmp_ready;
    assign vmp_data  = vmp_valid ? r_fifo[r_rd_ptr] : 16'd0;

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wr_ptr] <= {r_pipe_vm[RD_LAT-1], w_mem_sel};
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vm_proj_readout.sv
`default_nettype none
// ============================================================================
// tb_vm_proj_readout : scoreboard bench for vm_proj_readout   Revision: 1.0
// ============================================================================
module tb_vm_proj_readout;
    localparam int ADDR_W      = 9;
    localparam int RD_LAT      = 2;
    localparam int FIFO_DEPTH  = 4;
    localparam int MAX_ENTRIES = 511;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, start, vmp_ready;
    logic [5:0]  wr;
`ifdef VM_PROJ_READOUT_PAGE_EN
    logic [ADDR_W:0]   rd_add;
`else
    logic [ADDR_W-1:0] rd_add;
`endif
    logic        rd_en, vmp_valid, busy, done, overflow;
    logic [15:0] vmp_data;
    logic [12:0] m0, m1, m2, m3, m4, m5;
    logic [ADDR_W-1:0] p1, p2;

    vm_proj_readout #(
        .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH), .MAX_ENTRIES(MAX_ENTRIES)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .wr_en_phi1z1(wr[0]), .wr_en_phi1z2(wr[1]), .wr_en_phi2z1(wr[2]),
        .wr_en_phi2z2(wr[3]), .wr_en_phi3z1(wr[4]), .wr_en_phi3z2(wr[5]),
        .rd_add(rd_add), .rd_en(rd_en),
        .mem_phi1z1(m0), .mem_phi1z2(m1), .mem_phi2z1(m2),
        .mem_phi2z2(m3), .mem_phi3z1(m4), .mem_phi3z2(m5),
        .vmp_data(vmp_data), .vmp_valid(vmp_valid), .vmp_ready(vmp_ready),
        .busy(busy), .done(done), .overflow(overflow)
    );

    // Memory contents are a fixed function of (vm, address)
    function automatic logic [12:0] md(input int vm, input int a);
        int v;
        v = (vm * 1031 + a * 37 + 11) % 8192;
        return v[12:0];
    endfunction

    // Registered address, two-stage read latency
    always @(posedge clk) begin
        p1 <= rd_add[ADDR_W-1:0];
        p2 <= p1;
    end
    assign m0 = md(0, int'(p2));
    assign m1 = md(1, int'(p2));
    assign m2 = md(2, int'(p2));
    assign m3 = md(3, int'(p2));
    assign m4 = md(4, int'(p2));
    assign m5 = md(5, int'(p2));

    int n_chk = 0;
    int n_pass = 0;
    logic [15:0] sb[$];
    logic [ADDR_W-1:0] rd_q[$];
    int cnt_m [6];
    int ev_cyc, n_reads, first_valid, done_cyc;
    bit saw_busy, saw_valid, rand_ready, busy_at_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && vmp_valid && vmp_ready) begin
            if (sb.size() == 0) check_eq("sb_underflow", sb.size(), 1);
            else check_eq("vmp_data", vmp_data, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        tick();
        ev_cyc++;
        if (rd_en) begin
            n_reads++;
            rd_q.push_back(rd_add[ADDR_W-1:0]);
        end
        if (vmp_valid) begin
            saw_valid = 1'b1;
            if (first_valid < 0) first_valid = ev_cyc;
        end
        if (busy) saw_busy = 1'b1;
        if (rand_ready) vmp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wr_pulse(input int vm, input int n);
        wr[vm] = 1'b1;
        repeat (n) begin
            tick();
            if (cnt_m[vm] < MAX_ENTRIES) cnt_m[vm]++;
        end
        wr[vm] = 1'b0;
    endtask

    task automatic start_event(input logic [5:0] wr_same);
        logic [2:0] vv;
        rd_q.delete();
        n_reads = 0; first_valid = -1; ev_cyc = 0;
        saw_busy = 1'b0; saw_valid = 1'b0;
        for (int vm = 0; vm < 6; vm++) begin
            vv = 3'(vm);
            for (int a = 0; a < cnt_m[vm]; a++) sb.push_back({vv, md(vm, a)});
            cnt_m[vm] = wr_same[vm] ? 1 : 0;
        end
        wr = wr_same;
        start = 1'b1;
        step();
        start = 1'b0;
        wr = '0;
    endtask

    task automatic wait_done(input int max_cyc);
        while (done !== 1'b1 && ev_cyc < max_cyc) step();
        check_eq("done_seen", done, 1);
        done_cyc = ev_cyc;
        busy_at_done = busy;
        step();
        check_eq("done_pulse", done, 0);
        check_eq("sb_empty", sb.size(), 0);
    endtask

    initial begin
        int exp_rd [5];
        bit done_seen;
        exp_rd = '{0, 1, 2, 0, 1};
        for (int i = 0; i < 6; i++) cnt_m[i] = 0;
        reset_n = 1'b0; start = 1'b0; wr = '0; vmp_ready = 1'b1; rand_ready = 1'b0;
        repeat (3) tick();
        check_eq("rst_rd_en", rd_en, 0);
        check_eq("rst_rd_add", 32'(rd_add), 0);
        check_eq("rst_valid", vmp_valid, 0);
        check_eq("rst_data", vmp_data, 0);
        check_eq("rst_busy_done_ovf", {busy, done, overflow}, 0);
        reset_n = 1'b1;
        tick();

        // Basic: 3 in phi1z1, 2 in phi3z2
        wr_pulse(0, 3);
        wr_pulse(5, 2);
        start_event(6'b0);
        wait_done(100);
        check_eq("t1_first_valid", first_valid, RD_LAT + 2);
        check_eq("t1_done_cyc", done_cyc, 9);
        check_eq("t1_busy_at_done", busy_at_done, 0);
        check_eq("t1_saw_busy", saw_busy, 1);
        check_eq("t1_n_reads", n_reads, 5);
        for (int i = 0; i < 5; i++) check_eq("t1_rd_add", (i < rd_q.size()) ? 32'(rd_q[i]) : 32'hdead, exp_rd[i]);

        // Empty event
        start_event(6'b0);
        wait_done(20);
        check_eq("t2_done_cyc", done_cyc, 1);
        check_eq("t2_saw_valid", saw_valid, 0);
        check_eq("t2_saw_busy", saw_busy, 0);

        // Backpressure: 10 entries in phi2z1, ready low for 20 cycles
        wr_pulse(2, 10);
        vmp_ready = 1'b0;
        start_event(6'b0);
        repeat (19) step();
        check_eq("t3_stall_reads", n_reads, FIFO_DEPTH);
        check_eq("t3_stall_valid", vmp_valid, 1);
        check_eq("t3_stall_data", vmp_data, {3'd2, md(2, 0)});
        vmp_ready = 1'b1;
        wait_done(200);
        check_eq("t3_n_reads", n_reads, 10);

        // Write coinciding with start belongs to the next event
        start_event(6'b000010);
        wait_done(20);
        check_eq("t4_ev1_done_cyc", done_cyc, 1);
        start_event(6'b0);
        wait_done(50);
        check_eq("t4_ev2_n_reads", n_reads, 1);

        // Several VMs with random backpressure
        wr_pulse(0, 2); wr_pulse(2, 3); wr_pulse(3, 1); wr_pulse(5, 4);
        rand_ready = 1'b1;
        start_event(6'b0);
        wait_done(400);
        rand_ready = 1'b0;
        vmp_ready = 1'b1;
        check_eq("t5_n_reads", n_reads, 10);

        // Saturation
        wr_pulse(3, 510);
        check_eq("t6_ovf_before", overflow, 0);
        wr_pulse(3, 90);
        check_eq("t6_ovf_after", overflow, 1);
        start_event(6'b0);
        wait_done(2000);
        check_eq("t6_n_reads", n_reads, MAX_ENTRIES);
        check_eq("t6_ovf_sticky", overflow, 1);

        // Reset in the middle of an 8-entry readout
        wr_pulse(0, 8);
        start_event(6'b0);
        repeat (5) step();
        reset_n = 1'b0;
        tick();
        check_eq("t7_rst_outputs", {rd_en, vmp_valid, busy, done, overflow}, 0);
        check_eq("t7_rst_data", vmp_data, 0);
        check_eq("t7_rst_add", 32'(rd_add), 0);
        sb.delete();
        for (int i = 0; i < 6; i++) cnt_m[i] = 0;
        reset_n = 1'b1;
        done_seen = 1'b0;
        repeat (12) begin
            tick();
            if (done || busy) done_seen = 1'b1;
        end
        check_eq("t7_no_done", done_seen, 0);
        wr_pulse(4, 2);
        wr_pulse(1, 1);
        start_event(6'b0);
        wait_done(100);
        check_eq("t7_fresh_reads", n_reads, 3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vm_proj_readout.md
Name: vm_proj_readout

Overview:
- Downstream of the VM projection router; consumes the six VM projection memories (phi1z1..phi3z2) that the router fills.
- Counts the entries written into each memory during an event by watching the router's write enables.
- On an event boundary, it reads each memory back in fixed order and streams tagged projections to the match engine over a valid/ready handshake.
- Never issues a read that the output FIFO could not absorb.

Parameters:
- ADDR_W, 9, memory address width; also the counter width.
- RD_LAT, 2, cycles from rd_en to valid memory data.
- FIFO_DEPTH, 4, output FIFO entries; must be at least RD_LAT+1.
- MAX_ENTRIES, 511, saturation value for the per-VM counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle event boundary pulse.
- wr_en_phi1z1, wr_en_phi1z2, wr_en_phi2z1, wr_en_phi2z2, wr_en_phi3z1, wr_en_phi3z2  in  1 each  router write enables.
- rd_add  out  ADDR_W  shared read address to all six memories.
- rd_en  out  1  read strobe.
- mem_phi1z1 .. mem_phi3z2  in  13 each  memory read data ({index[5:0],phi[2:0],z[3:0]}).
- vmp_data  out  16  {vm_id[2:0], projection[12:0]}; vm_id 0..5 = phi1z1, phi1z2, phi2z1, phi2z2, phi3z1, phi3z2.
- vmp_valid  out  1  vmp_data valid.
- vmp_ready  in  1  downstream accepts.
- busy  out  1  readout in progress.
- done  out  1  one-cycle pulse after the last entry of the event leaves the FIFO.
- overflow  out  1  sticky; set when any counter saturates.

Behaviour:
- **Reset** (reset_n=0 at posedge):
  - rd_add=0, rd_en=0, vmp_data=0, vmp_valid=0, busy=0, done=0, overflow=0.
  - Counters and snapshots cleared; FIFO emptied; state IDLE.
  - Reset mid-readout abandons the event; no done is produced.
- **Fill counters:**
  - Six counters increment by 1 per cycle in which the matching wr_en is high.
  - Counters saturate at MAX_ENTRIES; overflow is set in the cycle saturation is reached.
- **start:**
  - Accepted only in IDLE.
  - Counts are copied to six snapshot registers and the counters are cleared.
  - A wr_en that is high in the same cycle as start counts into the cleared counter (value 1, belonging to the next event).
  - start in READ or DRAIN is ignored; counters keep accumulating.
- **FSM:**
  - IDLE -> READ on accepted start, provided at least one snapshot is nonzero.
  - If all snapshots are zero: IDLE -> DONE directly, so done pulses 1 cycle after start.
  - READ:
    - vm_sel starts at the lowest VM with a nonzero snapshot.
    - Each cycle where credit is available: rd_en=1, rd_add=addr, then addr increments.
    - When addr reaches snap[vm_sel]-1, advance to the next nonzero VM with addr=0, with no bubble.
    - After the last read: -> DRAIN.
  - DRAIN: wait until all outstanding reads have landed and the FIFO is empty -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
  - busy=1 in READ and DRAIN.
- **Credit:**
  - A read is issued only if FIFO occupancy plus in-flight reads is less than FIFO_DEPTH.
  - The in-flight count covers RD_LAT pipeline stages.
  - vm_sel is delayed RD_LAT cycles alongside rd_en to select which mem_* is captured into the FIFO.
- **Output:**
  - vmp_valid = FIFO not empty; the FIFO head drives vmp_data.
  - A pop occurs when vmp_valid && vmp_ready.
  - vmp_data is held stable while vmp_valid=1 and vmp_ready=0.
  - Simultaneous push and pop on a full FIFO is legal; occupancy is unchanged.
- **Ordering and latency:**
  - Output order is vm_id ascending, address ascending.
  - With vmp_ready held high, the first vmp_valid occurs RD_LAT+2 cycles after start.
  - Throughput is 1 entry/cycle.

Optional Feature:
- Macro VM_PROJ_READOUT_PAGE_EN enables page-based double buffering.
- When defined:
  - rd_add width becomes ADDR_W+1.
  - Its MSB is a page bit that toggles on every accepted start.
  - Reads target the page just closed, while the router writes the other page.
  - start is also accepted in READ/DRAIN; it is queued, at most one deep.
  - The queued start is taken in the cycle after DONE.
  - A second pending start sets overflow.
- When undefined:
  - rd_add is ADDR_W wide and there is no page bit.
  - start outside IDLE is ignored, as described above.

Test Plan:
- Reset, then pulse wr_en_phi1z1 3 times and wr_en_phi3z2 twice, then start with vmp_ready=1:
  - Expect reads at rd_add 0,1,2 then 0,1.
  - vmp_data vm_id sequence is 0,0,0,5,5, with the matching mem data.
  - done fires 1 cycle after the 5th output; busy falls with done.
- start with no prior writes -> done 1 cycle later; vmp_valid never asserts; busy stays 0.
- 10 entries in phi2z1, vmp_ready=0 for 20 cycles, then 1:
  - rd_en stops after 4 reads (FIFO_DEPTH).
  - vmp_data holds at the entry 0 value while stalled.
  - All 10 entries are delivered in order once ready rises.
- wr_en_phi1z2=1 in the same cycle as start → snapshot excludes that write; the next event's counter reads 1.
- 600 consecutive wr_en_phi2z2 → counter holds at 511 and overflow=1 until reset_n=0; readout emits 511 entries.
- Assert reset_n=0 midway through a readout of 8 entries → next cycle all outputs are 0 and the state is IDLE; no done; a fresh event afterwards reads correctly.
